// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave: register offsets, status bit positions
// and the frame FSM encoding.
package spi_slave_pkg;

   localparam logic [3:0] ADDR_STATUS      = 4'h0;
   localparam logic [3:0] ADDR_FROM_MASTER = 4'h4;
   localparam logic [3:0] ADDR_TO_MASTER   = 4'h8;

   localparam int STAT_FINISHED = 0;
   localparam int STAT_BUSY     = 1;
   localparam int STAT_ABORTED  = 2;
   localparam int STAT_OVERRUN  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/spi_slave_core.sv
// SPI slave engine: oversamples sck/ss_L/mosi in the clk domain and shifts
// one WID-bit frame (MSB first) per slave-select assertion.
module spi_slave_core
   import spi_slave_pkg::*;
#(
   parameter int WID      = 24,
   parameter int WID_LEN  = 5,
   parameter int POLARITY = 0,
   parameter int PHASE    = 0
) (
   input  logic           clk,
   input  logic           rst_L,
   input  logic           sck,
   input  logic           ss_L,
   input  logic           mosi,
   input  logic [WID-1:0] to_master,
   output logic [WID-1:0] from_master,
   output logic           miso,
   output logic           miso_oe,
   output logic           done,
   output logic           abort,
   output logic           busy
);

   localparam logic P_IDLE = (POLARITY != 0);

   logic [1:0]         r_sck_s, r_ss_s, r_mosi_s;
   logic               r_sck_d, r_ss_d;
   logic [1:0]         r_fill;
   logic               r_armed;
   state_t             r_state, w_state_next;
   logic [WID-1:0]     r_tx, r_rx, r_from;
   logic [WID_LEN-1:0] r_cnt;
   logic               r_miso, r_oe, r_busy;

   logic               w_sck, w_ss, w_mosi, w_lead, w_trail, w_ss_fall;
   logic               w_sample, w_drive, w_last, w_start, w_end;
   logic [WID_LEN-1:0] w_cnt_inc;
   logic [WID-1:0]     w_rx_next, w_tx_shl;

   assign w_sck     = r_sck_s[1];
   assign w_ss      = r_ss_s[1];
   assign w_mosi    = r_mosi_s[1];
   assign w_lead    = (r_sck_d == P_IDLE) && (w_sck != P_IDLE);
   assign w_trail   = (r_sck_d != P_IDLE) && (w_sck == P_IDLE);
   assign w_ss_fall = r_ss_d && !w_ss;
   assign w_sample  = (r_state == ST_SHIFT) && ((PHASE == 0) ? w_lead : w_trail);
   assign w_drive   = (r_state == ST_SHIFT) && ((PHASE == 0) ? w_trail : w_lead);
   assign w_cnt_inc = r_cnt + WID_LEN'(1);
   assign w_last    = w_sample && (w_cnt_inc == WID_LEN'(WID));
   assign w_rx_next = WID'({r_rx, w_mosi});
   assign w_tx_shl  = r_tx << 1;

   // A frame may only start after ss_L has genuinely been seen high, so a
   // reset released while the master still holds ss_L low cannot fake a fall.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_end        = 1'b0;
      done         = 1'b0;
      abort        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall && r_armed) begin
               w_state_next = ST_SHIFT;
               w_start      = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_last) begin
               w_state_next = ST_DONE;
               done         = 1'b1;
            end else if (w_ss) begin
               w_state_next = ST_IDLE;
               abort        = 1'b1;
            end
         end
         ST_DONE: begin
            if (w_ss) begin
               w_state_next = ST_IDLE;
               w_end        = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_sck_s  <= {2{P_IDLE}};
         r_ss_s   <= 2'b11;
         r_mosi_s <= 2'b00;
         r_sck_d  <= P_IDLE;
         r_ss_d   <= 1'b1;
         r_fill   <= 2'b00;
         r_armed  <= 1'b0;
         r_tx     <= '0;
         r_rx     <= '0;
         r_from   <= '0;
         r_cnt    <= '0;
         r_miso   <= 1'b0;
         r_oe     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_sck_s  <= {r_sck_s[0], sck};
         r_ss_s   <= {r_ss_s[0], ss_L};
         r_mosi_s <= {r_mosi_s[0], mosi};
         r_sck_d  <= w_sck;
         r_ss_d   <= w_ss;
         r_fill   <= {r_fill[0], 1'b1};
         if (r_fill[1] && w_ss) r_armed <= 1'b1;

         if (w_start) begin
            r_tx   <= to_master;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_oe   <= 1'b1;
            if (PHASE == 0) r_miso <= to_master[WID-1];
         end
         if (w_sample) begin
            r_rx  <= w_rx_next;
            r_cnt <= w_cnt_inc;
         end
         // CPHA=0 presents the next bit after a trailing edge; CPHA=1 presents it on the leading edge
         if (w_drive) begin
            r_tx   <= w_tx_shl;
            r_miso <= (PHASE == 0) ? w_tx_shl[WID-1] : r_tx[WID-1];
         end
         if (done) r_from <= w_rx_next;
         if (abort || w_end) begin
            r_busy <= 1'b0;
            r_miso <= 1'b0;
            r_oe   <= 1'b0;
         end
      end
   end

   assign from_master = r_from;
   assign miso        = r_miso;
   assign miso_oe     = r_oe;
   assign busy        = r_busy;

endmodule

// File: rtl/spi_slave_ss_wb.sv
// SPI slave with a Wishbone register front end: status, received word and
// reply word are exposed as three word-aligned registers.
module spi_slave_ss_wb
   import spi_slave_pkg::*;
#(
   parameter int BUS_WID  = 32,
   parameter int WID      = 24,
   parameter int WID_LEN  = 5,
   parameter int POLARITY = 0,
   parameter int PHASE    = 0
) (
   input  logic                 clk,
   input  logic                 rst_L,
   input  logic                 sck,
   input  logic                 ss_L,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   input  logic                 wb_cyc,
   input  logic                 wb_stb,
   input  logic                 wb_we,
   input  logic [BUS_WID/4-1:0] wb_sel,
   input  logic [BUS_WID-1:0]   wb_addr,
   input  logic [BUS_WID-1:0]   wb_dat_w,
   output logic                 wb_ack,
   output logic [BUS_WID-1:0]   wb_dat_r,
   output logic                 finished
);

   logic               r_ack;
   logic [BUS_WID-1:0] r_dat_r;
   logic [WID-1:0]     r_to_master;
   logic               r_finished, r_aborted, r_overrun;

   logic [WID-1:0]     w_from_master;
   logic               w_busy, w_done, w_abort;
   logic               w_access, w_rd, w_wr, w_st_wr;
   logic [3:0]         w_addr;
   logic [BUS_WID-1:0] w_status, w_rd_data;
   logic               w_unused;

   spi_slave_core #(
      .WID      (WID),
      .WID_LEN  (WID_LEN),
      .POLARITY (POLARITY),
      .PHASE    (PHASE)
   ) u_core (
      .clk         (clk),
      .rst_L       (rst_L),
      .sck         (sck),
      .ss_L        (ss_L),
      .mosi        (mosi),
      .to_master   (r_to_master),
      .from_master (w_from_master),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .done        (w_done),
      .abort       (w_abort),
      .busy        (w_busy)
   );

   assign w_access = wb_cyc && wb_stb && !r_ack;
   assign w_rd     = w_access && !wb_we;
   assign w_wr     = w_access && wb_we;
   assign w_addr   = wb_addr[3:0];
   assign w_st_wr  = w_wr && (w_addr == ADDR_STATUS);
   assign w_unused = ^{wb_sel, wb_addr, wb_dat_w};

   always_comb begin
      w_status                = '0;
      w_status[STAT_FINISHED] = r_finished;
      w_status[STAT_BUSY]     = w_busy;
      w_status[STAT_ABORTED]  = r_aborted;
      w_status[STAT_OVERRUN]  = r_overrun;
      w_rd_data               = '0;
      case (w_addr)
         ADDR_STATUS:      w_rd_data = w_status;
         ADDR_FROM_MASTER: w_rd_data = BUS_WID'(w_from_master);
         ADDR_TO_MASTER:   w_rd_data = BUS_WID'(r_to_master);
         default:          w_rd_data = '0;
      endcase
   end

   // Hardware set events take priority over CPU clears of the same bit.
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_ack       <= 1'b0;
         r_dat_r     <= '0;
         r_to_master <= '0;
         r_finished  <= 1'b0;
         r_aborted   <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_access)     r_ack <= 1'b1;
         else if (!wb_cyc) r_ack <= 1'b0;
         if (w_rd) r_dat_r <= w_rd_data;
         if (w_wr && (w_addr == ADDR_TO_MASTER)) r_to_master <= wb_dat_w[WID-1:0];

         if (w_done) r_finished <= 1'b1;
         else if (w_rd && (w_addr == ADDR_FROM_MASTER)) r_finished <= 1'b0;

         if (w_abort) r_aborted <= 1'b1;
         else if (w_st_wr && wb_dat_w[STAT_ABORTED]) r_aborted <= 1'b0;

         if (w_done && r_finished) r_overrun <= 1'b1;
         else if (w_st_wr && wb_dat_w[STAT_OVERRUN]) r_overrun <= 1'b0;
      end
   end

   assign wb_ack   = r_ack;
   assign wb_dat_r = r_dat_r;
   assign finished = r_finished;

endmodule

// File: tb/tb_spi_slave_ss_wb.sv
// Bench for spi_slave_ss_wb: a mode-0 and a mode-3 instance driven by a
// bit-level SPI master and Wishbone tasks, checked against a register-level model.
module tb_spi_slave_ss_wb;

   localparam int WID = 24;
   localparam int BW  = 32;
   localparam int H   = 80;   // sck half period = 8 clk

   logic clk = 1'b0, rst_L = 1'b0, mosi = 1'b0;
   logic sck0 = 1'b0, ss0 = 1'b1, sck3 = 1'b1, ss3 = 1'b1;
   logic cyc0 = 1'b0, cyc3 = 1'b0, stb = 1'b0, we = 1'b0;
   logic [BW/4-1:0] sel = '1;
   logic [BW-1:0]   addr = '0, dat_w = '0;
   logic miso0, oe0, ack0, fin0, miso3, oe3, ack3, fin3;
   logic [BW-1:0]   dr0, dr3;

   always #5 clk = ~clk;

   spi_slave_ss_wb #(.BUS_WID(BW), .WID(WID), .WID_LEN(5), .POLARITY(0), .PHASE(0)) dut0 (
      .clk(clk), .rst_L(rst_L), .sck(sck0), .ss_L(ss0), .mosi(mosi),
      .miso(miso0), .miso_oe(oe0), .wb_cyc(cyc0), .wb_stb(stb), .wb_we(we),
      .wb_sel(sel), .wb_addr(addr), .wb_dat_w(dat_w), .wb_ack(ack0),
      .wb_dat_r(dr0), .finished(fin0));

   spi_slave_ss_wb #(.BUS_WID(BW), .WID(WID), .WID_LEN(5), .POLARITY(1), .PHASE(1)) dut3 (
      .clk(clk), .rst_L(rst_L), .sck(sck3), .ss_L(ss3), .mosi(mosi),
      .miso(miso3), .miso_oe(oe3), .wb_cyc(cyc3), .wb_stb(stb), .wb_we(we),
      .wb_sel(sel), .wb_addr(addr), .wb_dat_w(dat_w), .wb_ack(ack3),
      .wb_dat_r(dr3), .finished(fin3));

   int vectors = 0, miscompares = 0;

   // register-level model, index 0 = mode-0 instance, 1 = mode-3 instance
   logic [WID-1:0] m_to[2], m_from[2];
   bit m_fin[2], m_abt[2], m_ovr[2], m_busy[2], m_armed[2];

   // frame in progress
   int f_m, f_bits;
   bit f_active;
   logic [WID-1:0] f_sent, f_exp, f_rcv;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic get_miso(input int m); return (m == 0) ? miso0 : miso3; endfunction
   function automatic logic get_oe(input int m);   return (m == 0) ? oe0 : oe3;     endfunction
   function automatic logic get_ack(input int m);  return (m == 0) ? ack0 : ack3;   endfunction
   function automatic logic get_fin(input int m);  return (m == 0) ? fin0 : fin3;   endfunction
   function automatic logic [BW-1:0] get_dr(input int m); return (m == 0) ? dr0 : dr3; endfunction

   task automatic set_sck(input int m, input logic v); if (m == 0) sck0 = v; else sck3 = v; endtask
   task automatic set_ss(input int m, input logic v);  if (m == 0) ss0 = v;  else ss3 = v;  endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_to[m] = '0; m_from[m] = '0;
         m_fin[m] = 0; m_abt[m] = 0; m_ovr[m] = 0; m_busy[m] = 0; m_armed[m] = 1;
      end
   endtask

   function automatic logic [BW-1:0] model_read(input int m, input logic [3:0] a);
      case (a)
         4'h0:    return {28'h0, m_ovr[m], m_abt[m], m_busy[m], m_fin[m]};
         4'h4:    return BW'(m_from[m]);
         4'h8:    return BW'(m_to[m]);
         default: return '0;
      endcase
   endfunction

   task automatic wb_xfer(input int m, input bit w, input logic [3:0] a,
                          input logic [BW-1:0] d, output logic [BW-1:0] q);
      bit got;
      addr = BW'(a); dat_w = d; we = w; stb = 1'b1;
      if (m == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
      got = 0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         got = get_ack(m);
      end
      check("wb_ack", BW'(got), 1);
      q = get_dr(m);
      stb = 1'b0; we = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0;
      @(posedge clk); #1;
      check("wb_ack_clear", BW'(get_ack(m)), 0);
      $display("wb dut%0d %s addr=%h wdata=%h rdata=%h", m, w ? "wr" : "rd", a, d, q);
   endtask

   task automatic wb_read(input int m, input logic [3:0] a, output logic [BW-1:0] q);
      logic [BW-1:0] exp;
      exp = model_read(m, a);
      if (a == 4'h0) check("finished_pin", BW'(get_fin(m)), BW'(m_fin[m]));
      wb_xfer(m, 1'b0, a, '0, q);
      check($sformatf("wb_rd_dut%0d_%h", m, a), q, exp);
      if (a == 4'h4) m_fin[m] = 0;
   endtask

   task automatic wb_write(input int m, input logic [3:0] a, input logic [BW-1:0] d);
      logic [BW-1:0] q;
      wb_xfer(m, 1'b1, a, d, q);
      if (a == 4'h0) begin
         if (d[2]) m_abt[m] = 0;
         if (d[3]) m_ovr[m] = 0;
      end
      if (a == 4'h8) m_to[m] = d[WID-1:0];
   endtask

   task automatic spi_start(input int m, input logic [WID-1:0] sent);
      f_m = m; f_sent = sent; f_bits = 0; f_rcv = '0;
      f_active = m_armed[m];
      if (f_active) begin
         f_exp = m_to[m];
         m_busy[m] = 1;
      end
      set_ss(m, 1'b0);
      #(H);
   endtask

   task automatic sample();
      logic mb;
      mb = get_miso(f_m);
      f_rcv = {f_rcv[WID-2:0], mb};
      if (f_active) begin
         check("miso_bit", BW'(mb), BW'(f_exp[WID-1-f_bits]));
         check("miso_oe", BW'(get_oe(f_m)), 1);
      end else begin
         check("miso_idle", BW'(mb), 0);
         check("miso_oe_idle", BW'(get_oe(f_m)), 0);
      end
   endtask

   task automatic spi_bits(input int n);
      logic b;
      for (int i = 0; i < n && f_bits < WID; i++) begin
         b = f_sent[WID-1-f_bits];
         if (f_m == 0) begin
            mosi = b; #(H);
            set_sck(0, 1'b1); sample(); #(H);
            set_sck(0, 1'b0);
         end else begin
            if (f_bits == 0 && f_active) check("miso_before_first_edge", BW'(get_miso(1)), 0);
            set_sck(1, 1'b0); mosi = b; #(H);
            set_sck(1, 1'b1); sample(); #(H);
         end
         f_bits++;
      end
   endtask

   task automatic spi_stop();
      #(H);
      set_ss(f_m, 1'b1);
      #(H);
      if (f_active) begin
         if (f_bits == WID) begin
            if (m_fin[f_m]) m_ovr[f_m] = 1;
            m_fin[f_m] = 1;
            m_from[f_m] = f_sent;
         end else begin
            m_abt[f_m] = 1;
         end
         m_busy[f_m] = 0;
      end
      m_armed[f_m] = 1;
      $display("spi dut%0d frame bits=%0d sent=%h received=%h", f_m, f_bits, f_sent, f_rcv);
   endtask

   task automatic full_frame(input int m, input logic [WID-1:0] sent);
      spi_start(m, sent); spi_bits(WID); spi_stop();
   endtask

   initial begin
      logic [BW-1:0] q;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_miso0", BW'(miso0), 0);  check("rst_oe0", BW'(oe0), 0);
      check("rst_ack0", BW'(ack0), 0);    check("rst_dr0", dr0, 0);
      check("rst_fin0", BW'(fin0), 0);    check("rst_miso3", BW'(miso3), 0);
      check("rst_oe3", BW'(oe3), 0);      check("rst_dr3", dr3, 0);
      rst_L = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // mode 0 and mode 3 reference frame
      for (int m = 0; m < 2; m++) begin
         wb_write(m, 4'h8, 32'h00123456);
         wb_read(m, 4'h8, q);
         full_frame(m, 24'hA5F00F);
         check("lit_rx_word", BW'(f_rcv), 32'h00123456);
         wb_read(m, 4'h0, q);  check("lit_status_done", q, 32'h1);
         wb_read(m, 4'h4, q);  check("lit_from_master", q, 32'h00A5F00F);
         wb_read(m, 4'h0, q);  check("lit_status_cleared", q, 32'h0);
      end

      // abort after 10 bits
      spi_start(0, 24'h777777); spi_bits(10); spi_stop();
      wb_read(0, 4'h0, q);  check("lit_status_abort", q, 32'h4);
      wb_read(0, 4'h4, q);  check("lit_from_kept", q, 32'h00A5F00F);
      wb_write(0, 4'h0, 32'h4);
      wb_read(0, 4'h0, q);  check("lit_status_w1c", q, 32'h0);
      wb_read(0, 4'hC, q);

      // overrun
      full_frame(0, 24'h000001);
      full_frame(0, 24'h000002);
      wb_read(0, 4'h0, q);  check("lit_status_overrun", q, 32'h9);
      wb_read(0, 4'h4, q);  check("lit_from_second", q, 32'h2);
      wb_write(0, 4'h0, 32'h8);
      wb_read(0, 4'h0, q);

      // reply word written mid-frame applies to the next frame only
      wb_write(0, 4'h8, 32'h00111111);
      spi_start(0, 24'h0F0F0F); spi_bits(5);
      wb_read(0, 4'h0, q);  check("lit_status_busy", q, 32'h2);
      wb_write(0, 4'h8, 32'h00ABCDEF);
      spi_bits(WID - 5); spi_stop();
      check("lit_rx_old_reply", BW'(f_rcv), 32'h00111111);
      full_frame(0, 24'hF0F0F0);
      check("lit_rx_new_reply", BW'(f_rcv), 32'h00ABCDEF);
      wb_read(0, 4'h4, q);

      // randomized frames on both instances
      for (int it = 0; it < 16; it++) begin
         int rm, rn;
         logic [WID-1:0] rw;
         rm = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 1) wb_write(rm, 4'h8, $urandom());
         rw = WID'($urandom());
         rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WID-1)) : WID;
         spi_start(rm, rw); spi_bits(rn); spi_stop();
         wb_read(rm, 4'h0, q);
         if ($urandom_range(0, 1) == 1) wb_read(rm, 4'h4, q);
         if ($urandom_range(0, 2) == 0) wb_write(rm, 4'h0, 32'hC);
         if ($urandom_range(0, 3) == 0) wb_read(rm, 4'h8, q);
      end

      // reset in the middle of a frame with ss_L kept low
      spi_start(0, 24'h5A5A5A); spi_bits(10);
      rst_L = 1'b0;
      #30;
      check("midrst_miso", BW'(miso0), 0);  check("midrst_oe", BW'(oe0), 0);
      check("midrst_ack", BW'(ack0), 0);    check("midrst_dr", dr0, 0);
      check("midrst_fin", BW'(fin0), 0);
      rst_L = 1'b1;
      model_reset();
      m_armed[0] = 0;
      f_active = 0;
      spi_bits(WID - 10); spi_stop();
      wb_read(0, 4'h0, q);  check("lit_status_after_rst", q, 32'h0);
      wb_read(0, 4'h4, q);
      wb_write(0, 4'h8, 32'h00C0FFEE);
      full_frame(0, 24'h3C3C3C);
      check("lit_rx_after_rst", BW'(f_rcv), 32'h00C0FFEE);
      wb_read(0, 4'h4, q);  check("lit_from_after_rst", q, 32'h003C3C3C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
